// File: rtl/fpq_peak_meter_if.sv
// Bundles the sample inputs and display outputs of the FPQ peak meter.
// The master side (value source / bench) drives samples and clears; the
// slave side (the meter) drives the LED bank and level indicators.
interface fpq_peak_meter_if #(
  parameter int WIDTH = 8,
  parameter int N_LED = 8
);
  localparam int LW = $clog2(N_LED + 1);

  logic [WIDTH-1:0] cur_value;
  logic             sample_valid;
  logic             peak_clr;
  logic [N_LED-1:0] cur_value_led;
  logic [LW-1:0]    bar_level;
  logic [LW-1:0]    peak_level;
  logic             overload;

  modport master (
    output cur_value, sample_valid, peak_clr,
    input  cur_value_led, bar_level, peak_level, overload
  );

  modport slave (
    input  cur_value, sample_valid, peak_clr,
    output cur_value_led, bar_level, peak_level, overload
  );
endinterface

// File: rtl/fpq_peak_meter.sv
// FPQ LED level meter: maps each sample to a thermometer bar (log2 or linear
// scale), overlays a peak-hold dot that holds and then decays one LED at a
// time, and keeps a sticky full-scale overload flag.
module fpq_peak_meter #(
  parameter int WIDTH        = 8,
  parameter int N_LED        = 8,
  parameter int LOG_MODE     = 1,
  parameter int HOLD_CYCLES  = 4,
  parameter int DECAY_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  fpq_peak_meter_if.slave    bus
);
  localparam int LW = $clog2(N_LED + 1);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int DW = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_RELOAD  = HW'(HOLD_CYCLES - 1);
  localparam logic [DW-1:0] DECAY_RELOAD = DW'(DECAY_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    DECAY
  } state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] bar_level_q, bar_level_d;
  logic [LW-1:0] peak_level_q, peak_level_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [DW-1:0] decay_cnt_q, decay_cnt_d;
  logic          overload_q, overload_d;
  logic [LW-1:0] new_level;
  logic [N_LED-1:0] led;
  logic          full_scale;

  assign full_scale = &bus.cur_value;

  generate
    if (LOG_MODE != 0) begin : g_log
      // Log2 scale: LED count is the position of the highest set bit, capped at N_LED.
      always_comb begin
        int msb;
        msb = 0;
        for (int i = 0; i < WIDTH; i++) begin
          if (bus.cur_value[i]) msb = i + 1;
        end
        new_level = (msb > N_LED) ? LW'(N_LED) : LW'(msb);
      end
    end else begin : g_lin
      logic [WIDTH+LW-1:0] prod;
      // Linear scale: ceil(v*N_LED / 2^WIDTH), the round-up being any nonzero low bits.
      always_comb begin
        prod      = {{LW{1'b0}}, bus.cur_value} * (WIDTH + LW)'(N_LED);
        new_level = prod[WIDTH+LW-1:WIDTH] + LW'(|prod[WIDTH-1:0]);
      end
    end
  endgenerate

  // Next-state logic for the bar, overload flag and the peak hold/decay FSM.
  always_comb begin
    state_d      = state_q;
    bar_level_d  = bar_level_q;
    peak_level_d = peak_level_q;
    hold_cnt_d   = hold_cnt_q;
    decay_cnt_d  = decay_cnt_q;
    overload_d   = overload_q;

    if (bus.sample_valid) bar_level_d = new_level;

    if (bus.peak_clr) overload_d = 1'b0;
    if (bus.sample_valid && full_scale) overload_d = 1'b1;

    if (bus.peak_clr) begin
      peak_level_d = bus.sample_valid ? new_level : '0;
      decay_cnt_d  = '0;
      if (peak_level_d != '0) begin
        state_d    = HOLD;
        hold_cnt_d = HOLD_RELOAD;
      end else begin
        state_d    = IDLE;
        hold_cnt_d = '0;
      end
    end else if (bus.sample_valid && (new_level != '0) && (new_level >= peak_level_q)) begin
      peak_level_d = new_level;
      hold_cnt_d   = HOLD_RELOAD;
      state_d      = HOLD;
    end else begin
      case (state_q)
        HOLD: begin
          if (hold_cnt_q != '0) begin
            hold_cnt_d = hold_cnt_q - HW'(1);
          end else begin
            state_d     = DECAY;
            decay_cnt_d = DECAY_RELOAD;
          end
        end
        DECAY: begin
          if (decay_cnt_q != '0) begin
            decay_cnt_d = decay_cnt_q - DW'(1);
          end else begin
            peak_level_d = peak_level_q - LW'(1);
            decay_cnt_d  = DECAY_RELOAD;
            if (peak_level_q == LW'(1)) state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bar_level_q  <= '0;
      peak_level_q <= '0;
      hold_cnt_q   <= '0;
      decay_cnt_q  <= '0;
      overload_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bar_level_q  <= bar_level_d;
      peak_level_q <= peak_level_d;
      hold_cnt_q   <= hold_cnt_d;
      decay_cnt_q  <= decay_cnt_d;
      overload_q   <= overload_d;
    end
  end

  // LED bank decoded purely from registers: thermometer bar plus peak dot.
  always_comb begin
    led = '0;
    for (int i = 0; i < N_LED; i++) begin
      if (LW'(i) < bar_level_q) led[i] = 1'b1;
      if (peak_level_q == LW'(i + 1)) led[i] = 1'b1;
    end
  end

  assign bus.cur_value_led = led;
  assign bus.bar_level     = bar_level_q;
  assign bus.peak_level    = peak_level_q;
  assign bus.overload      = overload_q;
endmodule

// File: tb/tb_fpq_peak_meter.sv
// Directed bench for the FPQ peak meter: a vector table for reset and the
// log-scale sweep, then hand-written hold/decay, re-arm, clear and
// linear-scale sequences.
module tb_fpq_peak_meter;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  // Free-running clock shared by both meter instances.
  always #5 clk = ~clk;

  fpq_peak_meter_if #(.WIDTH(8), .N_LED(8)) log_if ();
  fpq_peak_meter_if #(.WIDTH(8), .N_LED(8)) lin_if ();

  fpq_peak_meter #(.WIDTH(8), .N_LED(8), .LOG_MODE(1), .HOLD_CYCLES(4), .DECAY_CYCLES(2))
    u_log (.clk(clk), .rst_n(rst_n), .bus(log_if.slave));

  fpq_peak_meter #(.WIDTH(8), .N_LED(8), .LOG_MODE(0), .HOLD_CYCLES(4), .DECAY_CYCLES(2))
    u_lin (.clk(clk), .rst_n(rst_n), .bus(lin_if.slave));

  typedef struct {
    logic       rst_n;
    logic [7:0] v;
    logic       valid;
    logic       clr;
    logic [3:0] exp_bar;
    logic [3:0] exp_peak;
    logic [7:0] exp_led;
    logic       exp_ov;
  } vec_t;

  vec_t vecs[12];

  // Drive one cycle of inputs to both instances, then step past the edge.
  task automatic apply_stimulus(input logic r, input logic [7:0] v,
                                input logic valid, input logic clr);
    rst_n               = r;
    log_if.cur_value    = v;
    log_if.sample_valid = valid;
    log_if.peak_clr     = clr;
    lin_if.cur_value    = v;
    lin_if.sample_valid = valid;
    lin_if.peak_clr     = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_log(input string tag, input logic [3:0] bar, input logic [3:0] peak,
                           input logic [7:0] led, input logic ov);
    check_output({tag, " bar"},  32'(log_if.bar_level),     32'(bar));
    check_output({tag, " peak"}, 32'(log_if.peak_level),    32'(peak));
    check_output({tag, " led"},  32'(log_if.cur_value_led), 32'(led));
    check_output({tag, " ov"},   32'(log_if.overload),      32'(ov));
  endtask

  function automatic logic [7:0] bar_dot(input int bar, input int peak);
    logic [7:0] r;
    r = 8'((16'h1 << bar) - 16'h1);
    if (peak > 0) r = r | (8'h01 << (peak - 1));
    return r;
  endfunction

  // Main directed sequence.
  initial begin
    int ep;
    string tag;

    vecs[0]  = '{1'b0, 8'd255, 1'b1, 1'b0, 4'd0, 4'd0, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 8'd255, 1'b1, 1'b0, 4'd0, 4'd0, 8'h00, 1'b0};
    vecs[2]  = '{1'b1, 8'd0,   1'b1, 1'b0, 4'd0, 4'd0, 8'h00, 1'b0};
    vecs[3]  = '{1'b1, 8'd1,   1'b1, 1'b0, 4'd1, 4'd1, 8'h01, 1'b0};
    vecs[4]  = '{1'b1, 8'd2,   1'b1, 1'b0, 4'd2, 4'd2, 8'h03, 1'b0};
    vecs[5]  = '{1'b1, 8'd3,   1'b1, 1'b0, 4'd2, 4'd2, 8'h03, 1'b0};
    vecs[6]  = '{1'b1, 8'd4,   1'b1, 1'b0, 4'd3, 4'd3, 8'h07, 1'b0};
    vecs[7]  = '{1'b1, 8'd100, 1'b1, 1'b0, 4'd7, 4'd7, 8'h7F, 1'b0};
    vecs[8]  = '{1'b1, 8'd127, 1'b1, 1'b0, 4'd7, 4'd7, 8'h7F, 1'b0};
    vecs[9]  = '{1'b1, 8'd128, 1'b1, 1'b0, 4'd8, 4'd8, 8'hFF, 1'b0};
    vecs[10] = '{1'b1, 8'd255, 1'b1, 1'b0, 4'd8, 4'd8, 8'hFF, 1'b1};
    vecs[11] = '{1'b1, 8'd0,   1'b0, 1'b0, 4'd8, 4'd8, 8'hFF, 1'b1};

    for (int i = 0; i < 12; i++) begin
      apply_stimulus(vecs[i].rst_n, vecs[i].v, vecs[i].valid, vecs[i].clr);
      check_log($sformatf("vec%0d", i), vecs[i].exp_bar, vecs[i].exp_peak,
                vecs[i].exp_led, vecs[i].exp_ov);
    end

    // Hold then decay: capture 128, drop bar to 2, watch the dot fall.
    apply_stimulus(1'b0, 8'd0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'd128, 1'b1, 1'b0);
    check_log("hd k0", 4'd8, 4'd8, 8'hFF, 1'b0);
    for (int k = 1; k <= 22; k++) begin
      apply_stimulus(1'b1, (k == 1) ? 8'd2 : 8'd0, k == 1, 1'b0);
      if (k < 6) ep = 8;
      else ep = 7 - (k - 6) / 2;
      if (ep < 0) ep = 0;
      tag = $sformatf("hd k%0d", k);
      check_output({tag, " peak"}, 32'(log_if.peak_level), 32'(ep));
      check_output({tag, " led"},  32'(log_if.cur_value_led), 32'(bar_dot(2, ep)));
    end

    // Reset in the middle of a hold aborts it.
    apply_stimulus(1'b1, 8'd128, 1'b1, 1'b0);
    apply_stimulus(1'b1, 8'd0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 8'd0, 1'b0, 1'b0);
    check_log("midrst", 4'd0, 4'd0, 8'h00, 1'b0);
    apply_stimulus(1'b1, 8'd0, 1'b0, 1'b0);
    check_log("midrst+1", 4'd0, 4'd0, 8'h00, 1'b0);

    // Re-arm during decay at peak 5 with an equal-level sample.
    apply_stimulus(1'b1, 8'd128, 1'b1, 1'b0);
    for (int k = 1; k <= 10; k++) apply_stimulus(1'b1, 8'd0, 1'b0, 1'b0);
    check_output("rearm pre peak", 32'(log_if.peak_level), 32'd5);
    apply_stimulus(1'b1, 8'd20, 1'b1, 1'b0);
    check_log("rearm cap", 4'd5, 4'd5, 8'h1F, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      apply_stimulus(1'b1, 8'd0, 1'b0, 1'b0);
      check_output($sformatf("rearm hold%0d peak", k), 32'(log_if.peak_level), 32'd5);
    end
    apply_stimulus(1'b1, 8'd0, 1'b0, 1'b0);
    check_log("rearm drop", 4'd5, 4'd4, 8'h1F, 1'b0);

    // Clear with a simultaneous sample, then clear alone.
    apply_stimulus(1'b0, 8'd0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'd255, 1'b1, 1'b0);
    check_log("sim full", 4'd8, 4'd8, 8'hFF, 1'b1);
    apply_stimulus(1'b1, 8'd8, 1'b1, 1'b1);
    check_log("sim clr+v8", 4'd4, 4'd4, 8'h0F, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      apply_stimulus(1'b1, 8'd0, 1'b0, 1'b0);
      check_output($sformatf("sim hold%0d peak", k), 32'(log_if.peak_level), 32'd4);
    end
    apply_stimulus(1'b1, 8'd0, 1'b0, 1'b0);
    check_output("sim drop peak", 32'(log_if.peak_level), 32'd3);
    apply_stimulus(1'b1, 8'd0, 1'b0, 1'b1);
    check_log("clr alone", 4'd4, 4'd0, 8'h0F, 1'b0);
    apply_stimulus(1'b1, 8'd0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'd0, 1'b0, 1'b0);
    check_log("clr idle", 4'd4, 4'd0, 8'h0F, 1'b0);
    apply_stimulus(1'b1, 8'd255, 1'b1, 1'b1);
    check_log("clr+full", 4'd8, 4'd8, 8'hFF, 1'b1);
    apply_stimulus(1'b1, 8'd0, 1'b0, 1'b1);
    check_log("clr after full", 4'd8, 4'd0, 8'hFF, 1'b0);

    // Linear-scale instance.
    apply_stimulus(1'b0, 8'd0, 1'b0, 1'b0);
    check_output("lin rst bar", 32'(lin_if.bar_level), 32'd0);
    begin
      logic [7:0] lv [5];
      logic [3:0] lb [5];
      lv[0] = 8'd0;   lb[0] = 4'd0;
      lv[1] = 8'd1;   lb[1] = 4'd1;
      lv[2] = 8'd32;  lb[2] = 4'd1;
      lv[3] = 8'd33;  lb[3] = 4'd2;
      lv[4] = 8'd255; lb[4] = 4'd8;
      for (int i = 0; i < 5; i++) begin
        apply_stimulus(1'b1, lv[i], 1'b1, 1'b0);
        check_output($sformatf("lin v%0d bar", lv[i]), 32'(lin_if.bar_level), 32'(lb[i]));
      end
    end
    check_output("lin ov", 32'(lin_if.overload), 32'd1);
    check_output("lin led", 32'(lin_if.cur_value_led), 32'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
